// File: rtl/heartbeat_pkg.sv
// Shared constants and helpers for the DE1-SoC heartbeat indicator.
package heartbeat_pkg;

    localparam int STEPS        = 16;
    localparam int STEP_W       = $clog2(STEPS);
    localparam int BEAT_W       = 9;
    localparam int LUB_STEP     = 1;
    localparam int DUB_STEP     = 3;
    localparam int TICK_DIV_HW  = 5_000_000;
    localparam int TICK_DIV_SIM = 8;
    localparam int KEY_BTN_W    = 3;

    // Synchronized push-buttons, still active-low (1 = released).
    typedef struct packed {
        logic clear_n;
        logic fast_n;
        logic pause_n;
    } btn_t;

    // The "lub" and "dub" steps light the pulse LED.
    function automatic logic is_pulse_step(input logic [STEP_W-1:0] step);
        return (step == STEP_W'(LUB_STEP)) || (step == STEP_W'(DUB_STEP));
    endfunction

endpackage

// File: rtl/heartbeat_sync.sv
// Per-bit two-flop synchronizer that resets to 1 (button released).
module heartbeat_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/heartbeat_de1soc.sv
// DE1-SoC heartbeat: lub-dub pulse on LEDR[0], beat count on LEDR[9:1].
// Define HEARTBEAT_SIM_EN for a short simulation-friendly step divider.
module heartbeat_de1soc
    import heartbeat_pkg::*;
#(
`ifdef HEARTBEAT_SIM_EN
    parameter int TICK_DIV = TICK_DIV_SIM
`else
    parameter int TICK_DIV = TICK_DIV_HW
`endif
) (
    input  logic       CLOCK_50,
    input  logic       CLOCK2_50,
    input  logic       CLOCK3_50,
    input  logic       CLOCK4_50,
    input  logic [3:0] KEY,
    output logic [9:0] LEDR
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TERM_NORM = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TERM_FAST = CNT_W'(TICK_DIV / 4 - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    logic clk;
    logic rst_n;
    logic unused_clks;

    assign clk         = CLOCK_50;
    assign rst_n       = KEY[0];
    assign unused_clks = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50};

    logic [KEY_BTN_W-1:0] key_sync;
    btn_t                 btn;
    logic                 pause;
    logic                 fast;
    logic                 clear;

    heartbeat_sync #(
        .WIDTH (KEY_BTN_W)
    ) u_key_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (KEY[3:1]),
        .q     (key_sync)
    );

    assign btn   = btn_t'(key_sync);
    assign pause = ~btn.pause_n;
    assign fast  = ~btn.fast_n;
    assign clear = ~btn.clear_n;

    logic [CNT_W-1:0]  tick_cnt_reg, tick_cnt_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [CNT_W-1:0]  term_last;
    logic              terminal;
    logic              tick;

    // ">=" rather than "==" so dropping into fast rate above the new
    // terminal count wraps on the very next cycle.
    assign term_last = fast ? TERM_FAST : TERM_NORM;
    assign terminal  = (tick_cnt_reg >= term_last);
    assign tick      = ~pause & terminal;

    always_comb begin
        tick_cnt_next = tick_cnt_reg;
        step_next     = step_reg;
        beat_next     = beat_reg;
        if (!pause) begin
            if (terminal) begin
                tick_cnt_next = '0;
            end else begin
                tick_cnt_next = tick_cnt_reg + 1'b1;
            end
            if (tick) begin
                step_next = step_reg + 1'b1;
            end
            // Clear wins over the increment on the wrapping tick.
            if (clear) begin
                beat_next = '0;
            end else if (tick && (step_reg == LAST_STEP)) begin
                beat_next = beat_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
            step_reg     <= '0;
            beat_reg     <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
            step_reg     <= step_next;
            beat_reg     <= beat_next;
        end
    end

    assign LEDR = {beat_reg, is_pulse_step(step_reg)};

endmodule

// File: tb/tb_heartbeat_de1soc.sv
// Directed bench for heartbeat_de1soc with an 8-cycle step divider.
module tb_heartbeat_de1soc;

    logic       clk = 1'b0;
    logic [3:0] key = 4'hf;
    logic [9:0] ledr;
    int         checks = 0;
    int         errors = 0;
    int         now_cyc = 0;

    always #10 clk = ~clk;

    heartbeat_de1soc #(
        .TICK_DIV (8)
    ) dut (
        .CLOCK_50  (clk),
        .CLOCK2_50 (clk),
        .CLOCK3_50 (clk),
        .CLOCK4_50 (clk),
        .KEY       (key),
        .LEDR      (ledr)
    );

    task automatic check(input string tag, input logic [9:0] exp);
        checks++;
        assert (ledr === exp) else begin
            errors++;
            $error("FAIL %s: observed LEDR=%h expected %h (cycle %0d)", tag, ledr, exp, now_cyc);
        end
        $display("check %-14s cycle %0d LEDR=%h expected %h", tag, now_cyc, ledr, exp);
    endtask

    // Advance to 1 ns after rising edge number t (counted from reset release).
    task automatic goto(input int t);
        while (now_cyc < t) begin
            @(posedge clk);
            #1;
            now_cyc++;
        end
    endtask

    initial begin
        // Reset
        #500 key[0] = 1'b0;
        #500 check("rst_hold", 10'h000);
        #499 check("rst_end", 10'h000);
        #1   key[0] = 1'b1;             // t=1500, a falling edge
        now_cyc = 0;

        goto(7);   check("pre_tick", 10'h000);
        goto(8);   check("lub_rise", 10'h001);
        goto(15);  check("lub_hold", 10'h001);
        goto(16);  check("lub_fall", 10'h000);
        goto(24);  check("dub_rise", 10'h001);
        goto(32);  check("dub_fall", 10'h000);
        goto(127); check("step15", 10'h000);
        goto(128); check("beat1", 10'h002);
        goto(256); check("beat2", 10'h004);
        goto(264); check("beat2_lub", 10'h005);
        goto(384); check("beat3", 10'h006);

        // Pause mid-lub
        goto(394); key[1] = 1'b0;
        goto(420); check("pause_hold", 10'h007);
        goto(444); key[1] = 1'b1;
        goto(449); check("pause_tail", 10'h007);
        goto(450); check("pause_done", 10'h006);
        goto(562); check("beat4", 10'h008);

        // Fast rate
        key[2] = 1'b0;
        goto(564); check("fast_sync", 10'h008);
        goto(565); check("fast_lub", 10'h009);
        goto(566); check("fast_lub2", 10'h009);
        goto(567); check("fast_fall", 10'h008);
        goto(569); check("fast_dub", 10'h009);
        goto(571); check("fast_dubfall", 10'h008);
        goto(595); check("fast_beat5", 10'h00a);
        goto(627); check("fast_beat6", 10'h00c);

        // Back to normal rate
        key[2] = 1'b1;
        goto(629); check("norm_lub", 10'h00d);
        goto(636); check("norm_hold", 10'h00d);
        goto(637); check("norm_fall", 10'h00c);

        // Clear held
        key[3] = 1'b0;
        goto(639); check("clr_sync", 10'h00c);
        goto(640); check("clr_done", 10'h000);
        goto(645); check("clr_pulse", 10'h001);
        goto(749); check("clr_wrap", 10'h000);
        goto(757); check("clr_lub", 10'h001);

        // Asynchronous reset mid-pulse
        goto(760);
        #5 key = 4'b0110;
        #1 check("async_rst", 10'h000);
        @(negedge clk);
        check("rst_low", 10'h000);
        key = 4'hf;
        now_cyc = 0;
        goto(7);   check("re_pre", 10'h000);
        goto(8);   check("re_lub", 10'h001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
